// File: rtl/infix_to_postfix.sv
// Shunting-yard infix-to-postfix converter for the expression calculator.
// Emits RPN tokens on a registered valid/ready port and drives an external LIFO operator stack.
module infix_to_postfix #(
   parameter int DEPTH      = 6,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic                  stk_push,
   output logic                  stk_pop,
   output logic                  stk_flush,
   output logic [DATA_WIDTH-1:0] stk_wdata,
   input  logic                  stk_empty,
   input  logic [DATA_WIDTH-1:0] stk_top,
   output logic                  err
);

   typedef enum logic [2:0] {ACCEPT, REDUCE, PAREN, DRAIN, FLUSH} state_t;

   localparam logic [DATA_WIDTH-1:0] TOK_0     = DATA_WIDTH'(8'h30);
   localparam logic [DATA_WIDTH-1:0] TOK_9     = DATA_WIDTH'(8'h39);
   localparam logic [DATA_WIDTH-1:0] TOK_PLUS  = DATA_WIDTH'(8'h2B);
   localparam logic [DATA_WIDTH-1:0] TOK_MINUS = DATA_WIDTH'(8'h2D);
   localparam logic [DATA_WIDTH-1:0] TOK_MUL   = DATA_WIDTH'(8'h2A);
   localparam logic [DATA_WIDTH-1:0] TOK_LP    = DATA_WIDTH'(8'h28);
   localparam logic [DATA_WIDTH-1:0] TOK_RP    = DATA_WIDTH'(8'h29);
   localparam logic [DATA_WIDTH-1:0] TOK_EQ    = DATA_WIDTH'(8'h3D);
   localparam logic [DEPTH-1:0]      CNT_MAX   = '1;

   // '(' and anything unknown rank 0 so they never get popped by an incoming operator
   function automatic logic [1:0] precOf(input logic [DATA_WIDTH-1:0] tok);
      if (tok == TOK_MUL)
         return 2'd2;
      else if (tok == TOK_PLUS || tok == TOK_MINUS)
         return 2'd1;
      else
         return 2'd0;
   endfunction

   state_t                r_state;
   logic [DEPTH-1:0]      r_cnt;
   logic [DATA_WIDTH-1:0] r_pendOp;
   logic                  r_outValid;
   logic [DATA_WIDTH-1:0] r_outData;
   logic                  r_err;

   logic w_slotFree;
   logic w_accept;
   logic w_isDigit;
   logic w_isOp;
   logic w_isLp;
   logic w_isRp;
   logic w_isEq;
   logic w_cntFull;
   logic w_topIsLp;
   logic w_topPrecGe;
   logic w_redPop;
   logic w_redStop;

   assign w_slotFree  = !r_outValid || out_ready;
   assign w_accept    = (r_state == ACCEPT) && in_valid && w_slotFree;
   assign w_isDigit   = (in_data >= TOK_0) && (in_data <= TOK_9);
   assign w_isOp      = (in_data == TOK_PLUS) || (in_data == TOK_MINUS) || (in_data == TOK_MUL);
   assign w_isLp      = (in_data == TOK_LP);
   assign w_isRp      = (in_data == TOK_RP);
   assign w_isEq      = (in_data == TOK_EQ);
   assign w_cntFull   = (r_cnt == CNT_MAX);
   assign w_topIsLp   = (stk_top == TOK_LP);
   assign w_topPrecGe = precOf(stk_top) >= precOf(r_pendOp);
   assign w_redPop    = !stk_empty && w_topPrecGe && w_slotFree;
   assign w_redStop   = stk_empty || !w_topPrecGe;

   assign in_ready  = (r_state == ACCEPT) && w_slotFree;
   assign out_valid = r_outValid;
   assign out_data  = r_outData;
   assign err       = r_err;

   // Stack commands are decoded from the current state so push/pop/flush can never overlap
   always_comb begin
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      stk_flush = 1'b0;
      stk_wdata = in_data;
      case (r_state)
         ACCEPT: stk_push = w_accept && w_isLp && !w_cntFull;
         REDUCE: begin
            stk_wdata = r_pendOp;
            stk_pop   = w_redPop;
            stk_push  = !w_redPop && w_redStop && !w_cntFull;
         end
         PAREN:  stk_pop   = !stk_empty && (w_topIsLp || w_slotFree);
         DRAIN:  stk_pop   = !stk_empty && w_slotFree;
         FLUSH:  stk_flush = 1'b1;
         default: ;
      endcase
   end

   // Main FSM; the output register only loads when the slot is free, so back-pressure stalls every pop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ACCEPT;
         r_cnt      <= '0;
         r_pendOp   <= '0;
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_err      <= 1'b0;
      end else begin
         if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
            if (r_outData == TOK_EQ)
               r_err <= 1'b0;
         end
         case (r_state)
            ACCEPT: begin
               if (w_accept) begin
                  if (w_isDigit) begin
                     r_outValid <= 1'b1;
                     r_outData  <= in_data;
                  end else if (w_isLp) begin
                     if (w_cntFull)
                        r_err <= 1'b1;
                  end else if (w_isOp) begin
                     r_pendOp <= in_data;
                     r_state  <= REDUCE;
                  end else if (w_isRp) begin
                     r_state <= PAREN;
                  end else if (w_isEq) begin
                     r_pendOp <= in_data;
                     r_state  <= DRAIN;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            REDUCE: begin
               if (w_redPop) begin
                  r_outValid <= 1'b1;
                  r_outData  <= stk_top;
               end else if (w_redStop) begin
                  if (w_cntFull)
                     r_err <= 1'b1;
                  r_state <= ACCEPT;
               end
            end
            PAREN: begin
               if (stk_empty) begin
                  r_err   <= 1'b1;
                  r_state <= ACCEPT;
               end else if (w_topIsLp) begin
                  r_state <= ACCEPT;
               end else if (w_slotFree) begin
                  r_outValid <= 1'b1;
                  r_outData  <= stk_top;
               end
            end
            DRAIN: begin
               if (!stk_empty) begin
                  if (w_slotFree) begin
                     if (w_topIsLp) begin
                        r_err <= 1'b1;
                     end else begin
                        r_outValid <= 1'b1;
                        r_outData  <= stk_top;
                     end
                  end
               end else if (w_slotFree) begin
                  r_outValid <= 1'b1;
                  r_outData  <= r_pendOp;
                  r_state    <= FLUSH;
               end
            end
            FLUSH:   r_state <= ACCEPT;
            default: r_state <= ACCEPT;
         endcase
         if (stk_flush)
            r_cnt <= '0;
         else if (stk_push)
            r_cnt <= r_cnt + 1'b1;
         else if (stk_pop)
            r_cnt <= r_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_infix_to_postfix.sv
// Testbench for infix_to_postfix: small-capacity LIFO model, per-expression shunting-yard
// reference model, directed expressions and randomized token streams under back-pressure.
module tb_infix_to_postfix;

   localparam int DEPTH = 2;
   localparam int DW    = 8;
   localparam int CAP   = (1 << DEPTH) - 1;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic          stk_push;
   logic          stk_pop;
   logic          stk_flush;
   logic [DW-1:0] stk_wdata;
   logic          stk_empty;
   logic [DW-1:0] stk_top;
   logic          err;

   int checks;
   int failures;
   int readyMode;
   int flushCnt;
   int sp;
   logic [DW-1:0] mem [0:CAP];
   logic          accFlag;
   logic [DW-1:0] expQ [$];
   bit            expErrQ [$];
   string         gotStr;
   logic          holdPrev;
   logic [DW-1:0] prevData;

   infix_to_postfix #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_flush(stk_flush),
      .stk_wdata(stk_wdata), .stk_empty(stk_empty), .stk_top(stk_top),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External operator stack: slot 0 unused, top is combinational
   assign stk_empty = (sp == 0);
   assign stk_top   = mem[sp];

   initial begin
      for (int i = 0; i <= CAP; i++) mem[i] = '0;
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp <= 0;
      end else if (stk_flush) begin
         sp <= 0;
      end else if (stk_push) begin
         if (sp < CAP) begin
            mem[sp+1] <= stk_wdata;
            sp <= sp + 1;
         end
      end else if (stk_pop) begin
         if (sp > 0) sp <= sp - 1;
      end
   end

   always @(posedge clk) accFlag <= in_valid && in_ready;

   // Back-pressure pattern driver
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (readyMode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   function automatic int prec(input logic [DW-1:0] t);
      if (t == "*") return 2;
      if (t == "+" || t == "-") return 1;
      return 0;
   endfunction

   function automatic bit isOp(input logic [DW-1:0] t);
      return (t == "+") || (t == "-") || (t == "*");
   endfunction

   // Reference: whole-expression shunting-yard with a bounded operator stack
   function automatic void runModel(input string expr, output string outs, output bit e);
      logic [DW-1:0] stk [$];
      logic [DW-1:0] t;
      logic [DW-1:0] tk;
      outs = "";
      e = 1'b0;
      for (int i = 0; i < expr.len(); i++) begin
         t = expr[i];
         if (t >= "0" && t <= "9") begin
            outs = $sformatf("%s%c", outs, t);
         end else if (t == "(") begin
            if (stk.size() == CAP) e = 1'b1;
            else stk.push_back(t);
         end else if (isOp(t)) begin
            while (stk.size() > 0 && prec(stk[$]) >= prec(t)) begin
               tk = stk.pop_back();
               outs = $sformatf("%s%c", outs, tk);
            end
            if (stk.size() == CAP) e = 1'b1;
            else stk.push_back(t);
         end else if (t == ")") begin
            while (stk.size() > 0 && stk[$] != "(") begin
               tk = stk.pop_back();
               outs = $sformatf("%s%c", outs, tk);
            end
            if (stk.size() == 0) e = 1'b1;
            else tk = stk.pop_back();
         end else if (t == "=") begin
            while (stk.size() > 0) begin
               tk = stk.pop_back();
               if (tk == "(") e = 1'b1;
               else outs = $sformatf("%s%c", outs, tk);
            end
            outs = $sformatf("%s=", outs);
         end else begin
            e = 1'b1;
         end
      end
   endfunction

   // Single compare process: every output handshake, hold stability and stack protocol
   always @(negedge clk) begin
      logic [DW-1:0] expTok;
      bit            expErr;
      if (!rst) begin
         holdPrev <= 1'b0;
      end else begin
         if (holdPrev) begin
            checks++;
            if (!out_valid || out_data !== prevData) begin
               failures++;
               $display("[TB] FAIL hold_stable got valid=%0b data=%h exp valid=1 data=%h", out_valid, out_data, prevData);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            gotStr = $sformatf("%s%c", gotStr, out_data);
            if (expQ.size() == 0) begin
               failures++;
               $display("[TB] FAIL unexpected_out got=%h exp=none", out_data);
            end else begin
               expTok = expQ.pop_front();
               if (out_data !== expTok) begin
                  failures++;
                  $display("[TB] FAIL out_token got=%h exp=%h", out_data, expTok);
               end
               if (expTok == "=") begin
                  expErr = (expErrQ.size() > 0) ? expErrQ.pop_front() : 1'b0;
                  checks++;
                  if (err !== expErr) begin
                     failures++;
                     $display("[TB] FAIL err_at_eq got=%0b exp=%0b", err, expErr);
                  end
               end
            end
         end
         if (32'(stk_push) + 32'(stk_pop) + 32'(stk_flush) > 1 || (stk_push && sp == CAP) || (stk_pop && sp == 0)) begin
            failures++;
            $display("[TB] FAIL stack_protocol push=%0b pop=%0b flush=%0b sp=%0d exp legal single op", stk_push, stk_pop, stk_flush, sp);
         end
         if (stk_flush) flushCnt++;
         holdPrev <= out_valid && !out_ready;
         prevData <= out_data;
      end
   end

   task automatic check(input string name, input int got, input int expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("[TB] FAIL %s got=%0d exp=%0d", name, got, expv);
      end
   endtask

   task automatic checkStr(input string name, input string got, input string expv);
      checks++;
      if (got != expv) begin
         failures++;
         $display("[TB] FAIL %s got=\"%s\" exp=\"%s\"", name, got, expv);
      end
   endtask

   task automatic sendToken(input logic [DW-1:0] t);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = t;
      forever begin
         @(posedge clk);
         #1;
         if (accFlag) break;
         n++;
         if (n > 300) begin
            failures++;
            $display("[TB] FAIL accept_timeout got=no accept exp=accept of %h", t);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic expectExpr(input string expr);
      string outs;
      bit    e;
      runModel(expr, outs, e);
      for (int i = 0; i < outs.len(); i++) expQ.push_back(outs[i]);
      expErrQ.push_back(e);
   endtask

   task automatic waitDone();
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain_timeout got=%0d pending exp=0", expQ.size());
         expQ.delete();
         expErrQ.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input string expr);
      expectExpr(expr);
      gotStr = "";
      for (int i = 0; i < expr.len(); i++) sendToken(expr[i]);
      waitDone();
   endtask

   task automatic checkOutput(input string expr, input string expOut, input int flushBefore);
      checkStr({"out_", expr}, gotStr, expOut);
      check({"flush_", expr}, flushCnt - flushBefore, 1);
      check({"sp_", expr}, sp, 0);
   endtask

   task automatic checkModel(input string expr, input string expOut, input bit expErr);
      string outs;
      bit    e;
      runModel(expr, outs, e);
      checkStr({"model_", expr}, outs, expOut);
      check({"model_err_", expr}, int'(e), int'(expErr));
   endtask

   initial begin
      int    fb;
      string alpha;
      string expr;
      int    len;
      checks    = 0;
      failures  = 0;
      readyMode = 0;
      flushCnt  = 0;
      holdPrev  = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      gotStr    = "";
      rst       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_out_data", int'(out_data), 0);
      check("reset_err", int'(err), 0);
      check("reset_stk_ops", int'({stk_push, stk_pop, stk_flush}), 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("idle_in_ready", int'(in_ready), 1);

      checkModel("3+4*2=", "342*+=", 1'b0);
      checkModel("(1+2)*3=", "12+3*=", 1'b0);
      checkModel("8-3-2=", "83-2-=", 1'b0);
      checkModel("1)+2=", "12+=", 1'b1);
      checkModel("((((1=", "1=", 1'b1);

      fb = flushCnt;
      applyStimulus("3+4*2=");
      checkOutput("3+4*2=", "342*+=", fb);
      check("err_after_3+4*2", int'(err), 0);

      fb = flushCnt;
      applyStimulus("(1+2)*3=");
      checkOutput("(1+2)*3=", "12+3*=", fb);

      readyMode = 1;
      fb = flushCnt;
      applyStimulus("8-3-2=");
      checkOutput("8-3-2=", "83-2-=", fb);
      readyMode = 0;

      fb = flushCnt;
      expectExpr("1)+2=");
      gotStr = "";
      sendToken("1");
      sendToken(")");
      sendToken("+");
      check("err_after_rparen", int'(err), 1);
      sendToken("2");
      sendToken("=");
      waitDone();
      checkOutput("1)+2=", "12+=", fb);
      check("err_cleared_on_eq", int'(err), 0);

      fb = flushCnt;
      applyStimulus("((((1=");
      checkOutput("((((1=", "1=", fb);

      // Abandon an expression while REDUCE wants to pop '*'
      expQ.push_back("2");
      expQ.push_back("3");
      sendToken("2");
      sendToken("*");
      sendToken("3");
      sendToken("+");
      check("reduce_pop_pending", int'(stk_pop), 1);
      rst = 1'b0;
      expQ.delete();
      expErrQ.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("midreset_out_valid", int'(out_valid), 0);
      check("midreset_err", int'(err), 0);
      check("midreset_in_ready", int'(in_ready), 1);
      fb = flushCnt;
      applyStimulus("5=");
      checkOutput("5=", "5=", fb);

      readyMode = 2;
      alpha = "0123456789++-*(()x";
      for (int k = 0; k < 40; k++) begin
         expr = "";
         len = $urandom_range(0, 10);
         for (int j = 0; j < len; j++)
            expr = $sformatf("%s%c", expr, alpha[$urandom_range(0, alpha.len() - 1)]);
         expr = {expr, "="};
         applyStimulus(expr);
      end
      readyMode = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/infix_to_postfix.md
Name: infix_to_postfix

Overview:
- Shunting-yard front end of the arithmetic expression calculator.
- Accepts an ASCII infix token stream and emits the equivalent postfix (RPN) token stream to the evaluator.
- Is the initiator of the operator-stack interface: it drives push/pop/flush and consumes empty/top from the external 8-bit LIFO stack block.

Parameters:
DEPTH, 6, stack pointer width of the attached stack; usable capacity 2^DEPTH-1 entries (pointer 0 = empty, slot 0 unused).
DATA_WIDTH, 8, token width (ASCII).

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  infix token valid
in_data  input  DATA_WIDTH  infix token
in_ready  output  1  token accepted when in_valid&&in_ready
out_valid  output  1  postfix token valid (registered)
out_data  output  DATA_WIDTH  postfix token (registered)
out_ready  input  1  downstream accepts when out_valid&&out_ready
stk_push  output  1  push stk_wdata; the stack writes slot sp+1 and increments sp
stk_pop  output  1  pop; the stack decrements sp
stk_flush  output  1  stack sp -> 0
stk_wdata  output  DATA_WIDTH  push data
stk_empty  input  1  stack empty
stk_top  input  DATA_WIDTH  stack[sp], combinational; reflects a push/pop on the next cycle
err  output  1  sticky expression error

Behaviour:
- Tokens:
  - operand: '0'..'9'
  - operators: '+', '-' (precedence 1), '*' (precedence 2)
  - '(' (precedence 0 on the stack), ')'
  - '=' terminates the expression
  - anything else is invalid.
- Output slot "free" = !out_valid || out_ready.
  - The output register loads only when the slot is free; otherwise it holds its data.
  - out_valid clears after the handshake if no new load occurs.
- stk_push, stk_pop and stk_flush are mutually exclusive, one-cycle, combinational from state. At most one stack op per cycle.
- Internal counter cnt tracks stack occupancy (0..2^DEPTH-1) and mirrors the attached stack.
- FSM states: ACCEPT, REDUCE, PAREN, DRAIN, FLUSH.
- ACCEPT:
  - in_ready = slot free.
  - On accept:
    - operand: load out_data = token; stay in ACCEPT.
    - '(': push, unless cnt == max, in which case err=1 and the token is dropped; stay in ACCEPT.
    - operator: latch into pend_op; go to REDUCE.
    - ')': go to PAREN.
    - '=': latch the end marker; go to DRAIN.
    - invalid: err=1; token dropped; stay in ACCEPT.
- REDUCE (in_ready=0):
  - If !stk_empty && prec(stk_top) >= prec(pend_op) && slot free: pop and load out_data = stk_top.
  - Else if the stop condition holds (stk_empty, or lower precedence on top): push pend_op and return to ACCEPT. If cnt == max, set err=1 and do not push.
  - Else: wait.
- PAREN (in_ready=0):
  - stk_empty: err=1 (unmatched ')'); go to ACCEPT.
  - top == '(': pop, discard, no output; go to ACCEPT.
  - Otherwise, when slot free: pop and emit top.
- DRAIN:
  - While !stk_empty: pop, one per cycle, when slot free.
  - A '(' left on the stack sets err=1 and is discarded, not emitted.
  - When empty and slot free: load '='; go to FLUSH.
- FLUSH:
  - Assert stk_flush for one cycle; cnt=0; go to ACCEPT.
  - err clears on the '=' output handshake.
- Throughput: one token per cycle (accept or pop+emit), absent back-pressure.
- Left associativity comes from >= in REDUCE: "8-3-2" -> "83-2-".
- Reset (rst low, asynchronous):
  - state = ACCEPT, cnt = 0, out_valid = 0, out_data = 0, err = 0, pend_op = 0.
  - All stack controls = 0.
  - Reset mid-expression does not touch the stack. The calculator resets the stack from the same reset.
- Back-pressure: out_ready low freezes the state. No pop or push is issued while a pop's output cannot load.

Test Plan:
- "3+4*2=" with out_ready=1 -> outputs '3','4','2','*','+','='; err=0; stk_flush pulses once after '='; cnt=0.
- "(1+2)*3=" -> "12+3*="; the '(' is popped silently in PAREN; no '(' or ')' appears on the output.
- "8-3-2=" with out_ready toggling 1,0 each cycle -> "83-2-="; each output held stable while out_ready=0; no token lost or duplicated.
- "1)+2=" -> err rises on ')', stays high while the remaining tokens flow; output "12+="; err clears on the '=' handshake.
- DEPTH=2: "((((1=" -> the 4th '(' sets err (capacity 3); DRAIN discards 3 '(' with no output; output "1="; stk_flush pulses.
- Reset asserted in REDUCE mid-expression -> out_valid=0, err=0, in_ready=1 after release; "5=" yields "5=".
